// File: rtl/lbm_sweep_scheduler_pkg.sv
// lbm_sweep_scheduler_pkg: lattice geometry defaults and scheduler state encoding.
// Rev 1.0
`default_nettype none

package lbm_sweep_scheduler_pkg;

  localparam int DEF_GRID_W   = 50;
  localparam int DEF_GRID_H   = 50;
  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_PIPE_LAT = 4;
  localparam int DEPTH        = DEF_GRID_W * DEF_GRID_H;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SWEEP  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SWAP   = 3'd3,
    ST_HOST_A = 3'd4,
    ST_HOST_B = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/lbm_wb_delay.sv
// lbm_wb_delay: PIPE_LAT-deep {valid, addr} shift producing the write-back strobe and address.
// Rev 1.0
`default_nettype none

module lbm_wb_delay #(
  parameter int ADDR_W   = 12,
  parameter int PIPE_LAT = 4
) (
  input  logic              clk,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              pending_o
);

  logic [PIPE_LAT-1:0] valid_q;
  logic [ADDR_W-1:0]   addr_q [PIPE_LAT];

  // Shifts every cycle so bubbles keep the issue-to-write distance fixed.
  always_ff @(posedge clk) begin
    if (flush_i) begin
      valid_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      addr_q[0]  <= valid_i ? addr_i : '0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign wr_en_o   = valid_q[PIPE_LAT-1];
  assign wr_addr_o = addr_q[PIPE_LAT-1];
  assign pending_o = |valid_q;

endmodule

`default_nettype wire

// File: rtl/lbm_sweep_scheduler.sv
// lbm_sweep_scheduler: per-timestep raster sweep, delayed write-back, bank swap and host readout slots.
// Rev 1.0
`default_nettype none

module lbm_sweep_scheduler
  import lbm_sweep_scheduler_pkg::*;
#(
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [31:0]       step_i,
  input  logic              collider_ready_i,
  input  logic              host_req_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_valid_o,
  output logic [5:0]        rd_x_o,
  output logic [5:0]        rd_y_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              wr_en_o,
  output logic              bank_sel_o,
  output logic              host_grant_o,
  output logic              host_ack_o,
  output logic              in_collision_state_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       steps_done_o
);

  localparam logic [5:0]        X_LAST    = 6'(GRID_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(GRID_W * GRID_H - 1);

  state_e            state_q, ret_q;
  logic [5:0]        x_q, y_q;
  logic [ADDR_W-1:0] addr_q;
  logic              bank_q;
  logic [31:0]       step_q, steps_done_q;
  logic              issue, pending;

  assign issue = (state_q == ST_SWEEP) && collider_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ret_q        <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      bank_q       <= 1'b0;
      step_q       <= '0;
      steps_done_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (host_req_i) begin
            state_q <= ST_HOST_A;
            ret_q   <= ST_IDLE;
          end else if (en_i) begin
            step_q       <= step_i;
            steps_done_q <= '0;
            state_q      <= (step_i == 32'd0) ? ST_DONE : ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (collider_ready_i) begin
            // Linear address tracks x/y with an increment instead of y*GRID_W+x.
            addr_q <= addr_q + ADDR_W'(1);
            if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= y_q + 6'd1;
            end else begin
              x_q <= x_q + 6'd1;
            end
            if (addr_q == ADDR_LAST) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!pending) state_q <= ST_SWAP;
        end
        ST_SWAP: begin
          bank_q       <= ~bank_q;
          steps_done_q <= steps_done_q + 32'd1;
          x_q          <= '0;
          y_q          <= '0;
          addr_q       <= '0;
          if ((steps_done_q + 32'd1) == step_q) begin
            state_q <= ST_DONE;
          end else if (!en_i) begin
            state_q <= ST_IDLE;
          end else if (host_req_i) begin
            state_q <= ST_HOST_A;
            ret_q   <= ST_SWEEP;
          end else begin
            state_q <= ST_SWEEP;
          end
        end
        ST_HOST_A: state_q <= ST_HOST_B;
        ST_HOST_B: state_q <= ret_q;
        ST_DONE: begin
          if (host_req_i) begin
            state_q <= ST_HOST_A;
            ret_q   <= ST_DONE;
          end else if (!en_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  lbm_wb_delay #(
    .ADDR_W  (ADDR_W),
    .PIPE_LAT(PIPE_LAT)
  ) u_wb_delay (
    .clk      (clk),
    .flush_i  (rst),
    .valid_i  (issue),
    .addr_i   (addr_q),
    .wr_en_o  (wr_en_o),
    .wr_addr_o(wr_addr_o),
    .pending_o(pending)
  );

  assign rd_valid_o           = issue;
  assign rd_addr_o            = (state_q == ST_SWEEP)  ? addr_q :
                                (state_q == ST_HOST_A) ? host_addr_i : '0;
  assign rd_x_o               = (state_q == ST_SWEEP) ? x_q : '0;
  assign rd_y_o               = (state_q == ST_SWEEP) ? y_q : '0;
  assign bank_sel_o           = bank_q;
  assign host_grant_o         = (state_q == ST_HOST_A);
  assign host_ack_o           = (state_q == ST_HOST_B);
  assign in_collision_state_o = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
  assign busy_o               = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o               = (state_q == ST_DONE);
  assign steps_done_o         = steps_done_q;

endmodule

`default_nettype wire

// File: tb/tb_lbm_sweep_scheduler.sv
// tb_lbm_sweep_scheduler: directed self-checking bench with a write-back delay scoreboard.
// Rev 1.0
`default_nettype none

module tb_lbm_sweep_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] step = '0;
  logic        ready = 1'b0;
  logic        host_req = 1'b0;
  logic [11:0] host_addr = '0;
  logic [11:0] rd_addr, wr_addr;
  logic        rd_valid, wr_en, bank_sel, host_grant, host_ack, in_coll, busy, done;
  logic [5:0]  rd_x, rd_y;
  logic [31:0] steps_done;

  int checks = 0;
  int failures = 0;
  int exp_addr = 0;
  int issues = 0;
  logic [3:0]  hv = '0;
  logic [11:0] ha [4];

  always #5 clk = ~clk;

  lbm_sweep_scheduler dut (
    .clk(clk), .rst(rst), .en_i(en), .step_i(step), .collider_ready_i(ready),
    .host_req_i(host_req), .host_addr_i(host_addr),
    .rd_addr_o(rd_addr), .rd_valid_o(rd_valid), .rd_x_o(rd_x), .rd_y_o(rd_y),
    .wr_addr_o(wr_addr), .wr_en_o(wr_en), .bank_sel_o(bank_sel),
    .host_grant_o(host_grant), .host_ack_o(host_ack),
    .in_collision_state_o(in_coll), .busy_o(busy), .done_o(done),
    .steps_done_o(steps_done)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Inputs are set at a negedge; outputs are sampled 2 units later, before the posedge.
  task automatic cyc();
    #2;
    chk("wr_en", {63'd0, wr_en}, {63'd0, hv[3]});
    if (hv[3]) chk("wr_addr", {52'd0, wr_addr}, {52'd0, ha[3]});
    chk("wr_grant_excl", {63'd0, wr_en & host_grant}, 64'd0);
    if (rd_valid) begin
      chk("rd_addr", {52'd0, rd_addr}, 64'(exp_addr));
      chk("rd_x", {58'd0, rd_x}, 64'(exp_addr % 50));
      chk("rd_y", {58'd0, rd_y}, 64'(exp_addr / 50));
      exp_addr = (exp_addr + 1) % 2500;
      issues++;
    end
    for (int i = 3; i > 0; i--) begin
      hv[i] = hv[i-1];
      ha[i] = ha[i-1];
    end
    hv[0] = rd_valid;
    ha[0] = rd_addr;
    if (rst) hv = '0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ready = 1'b0; host_req = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    exp_addr = 0;
    issues = 0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      cyc();
      n++;
    end
    chk("done_within_budget", {63'd0, done}, 64'd1);
  endtask

  initial begin
    int n;
    logic pc1, pc2;
    for (int i = 0; i < 4; i++) ha[i] = '0;
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_rd_addr", {52'd0, rd_addr}, 64'd0);
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_bank", {63'd0, bank_sel}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_steps", {32'd0, steps_done}, 64'd0);
    chk("rst_grant", {62'd0, host_grant, host_ack}, 64'd0);

    // One timestep, collider always ready, en pulsed
    step = 32'd1; ready = 1'b1; en = 1'b1;
    cyc();
    en = 1'b0;
    chk("t1_first_issue", {63'd0, rd_valid}, 64'd1);
    chk("t1_in_coll", {62'd0, in_coll, busy}, 64'd3);
    wait_done(3000);
    chk("t1_issues", 64'(issues), 64'd2500);
    chk("t1_bank", {63'd0, bank_sel}, 64'd1);
    chk("t1_steps", {32'd0, steps_done}, 64'd1);
    cyc();
    chk("t1_done_clear", {62'd0, done, busy}, 64'd0);

    // Three timesteps with alternating bubbles
    do_reset();
    step = 32'd3; en = 1'b1; ready = 1'b1;
    n = 0;
    while (!done && n < 20000) begin
      cyc();
      ready = ~ready;
      n++;
    end
    chk("t2_done", {63'd0, done}, 64'd1);
    chk("t2_issues", 64'(issues), 64'd7500);
    chk("t2_bank", {63'd0, bank_sel}, 64'd1);
    chk("t2_steps", {32'd0, steps_done}, 64'd3);
    en = 1'b0; ready = 1'b1;
    cyc();

    // Host readout slot at the first timestep boundary of a two-step run
    do_reset();
    step = 32'd2; en = 1'b1; ready = 1'b1;
    for (int i = 0; i < 100; i++) cyc();
    host_req = 1'b1; host_addr = 12'd1234;
    n = 0; pc1 = 1'b0; pc2 = 1'b0;
    while (!host_grant && n < 3000) begin
      pc2 = pc1;
      pc1 = in_coll;
      cyc();
      n++;
    end
    chk("t3_grant", {63'd0, host_grant}, 64'd1);
    chk("t3_grant_addr", {52'd0, rd_addr}, 64'd1234);
    chk("t3_grant_novalid", {63'd0, rd_valid}, 64'd0);
    chk("t3_after_swap", {62'd0, pc2, pc1}, 64'd2);
    chk("t3_bank", {63'd0, bank_sel}, 64'd1);
    chk("t3_steps", {32'd0, steps_done}, 64'd1);
    cyc();
    chk("t3_ack", {62'd0, host_ack, host_grant}, 64'd2);
    host_req = 1'b0;
    cyc();
    chk("t3_restart_valid", {63'd0, rd_valid}, 64'd1);
    chk("t3_restart_addr", {52'd0, rd_addr}, 64'd0);
    wait_done(3000);
    chk("t3_issues", 64'(issues), 64'd5000);
    chk("t3_bank_end", {63'd0, bank_sel}, 64'd0);
    chk("t3_steps_end", {32'd0, steps_done}, 64'd2);
    en = 1'b0;
    cyc();

    // en dropped mid-sweep finishes the current timestep then idles
    do_reset();
    step = 32'd5; en = 1'b1; ready = 1'b1;
    n = 0;
    while (issues < 600 && n < 1000) begin
      cyc();
      n++;
    end
    en = 1'b0;
    n = 0;
    while (busy && n < 3000) begin
      cyc();
      n++;
    end
    chk("t4_idle", {62'd0, busy, done}, 64'd0);
    chk("t4_issues", 64'(issues), 64'd2500);
    chk("t4_steps", {32'd0, steps_done}, 64'd1);
    chk("t4_bank", {63'd0, bank_sel}, 64'd1);

    // Reset mid-sweep aborts and flushes pending writes
    do_reset();
    step = 32'd2; en = 1'b1; ready = 1'b1;
    n = 0;
    while (issues < 1000 && n < 2000) begin
      cyc();
      n++;
    end
    chk("t5_wr_before", {63'd0, wr_en}, 64'd1);
    rst = 1'b1; en = 1'b0;
    cyc();
    rst = 1'b0;
    chk("t5_zero_rd", {39'd0, rd_valid, rd_addr, rd_x, rd_y}, 64'd0);
    chk("t5_zero_wr", {51'd0, wr_en, wr_addr}, 64'd0);
    chk("t5_zero_misc", {57'd0, bank_sel, host_grant, host_ack, in_coll, busy, done}, 64'd0);
    chk("t5_zero_steps", {32'd0, steps_done}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      chk("t5_no_wr", {63'd0, wr_en}, 64'd0);
      cyc();
    end

    // step=0 completes at once; host slot served from DONE
    do_reset();
    step = 32'd0; en = 1'b1; ready = 1'b1;
    cyc();
    chk("t6_done", {63'd0, done}, 64'd1);
    chk("t6_bank", {63'd0, bank_sel}, 64'd0);
    host_req = 1'b1; host_addr = 12'd7;
    cyc();
    chk("t6_grant_addr", {51'd0, host_grant, rd_addr}, 64'h1007);
    cyc();
    chk("t6_ack", {63'd0, host_ack}, 64'd1);
    host_req = 1'b0;
    cyc();
    chk("t6_back_done", {63'd0, done}, 64'd1);
    en = 1'b0;
    cyc();
    chk("t6_issues", 64'(issues), 64'd0);
    chk("t6_idle", {62'd0, done, bank_sel}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
